// File: rtl/ray_dispatcher_pkg.sv
// Shared types and constants for the ray dispatcher and its result FIFO.
package ray_dispatcher_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int CORE_LATENCY = 5;
    localparam int FOCAL_Z_DEF  = 31;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int ADDR_W       = 19;
    localparam int COORD_W      = 16;
    localparam int RES_W        = 1 + ADDR_W + 1;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } Pixel_s;

    // Single sphere scene: centre and squared radius.
    typedef struct packed {
        logic signed [COORD_W-1:0] cx;
        logic signed [COORD_W-1:0] cy;
        logic signed [COORD_W-1:0] cz;
        logic        [COORD_W-1:0] radius_sq;
    } World_s;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/ray_dispatcher_hit_fifo.sv
// Show-ahead synchronous FIFO for {hit, addr, last}; head reads as zero when empty.
module hit_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      valid,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign valid = (r_count != '0);
    assign head  = valid ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule

// File: rtl/ray_dispatcher.sv
// Frame sequencer for the ray-trace core: raster issue, latency realignment, in-order hit stream.
// Optional hit counter output enabled by defining RAY_HIT_COUNT_EN.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int H_RES        = SCREEN_W,
    parameter int V_RES        = SCREEN_H,
    parameter int FOCAL_Z      = FOCAL_Z_DEF,
    parameter int CORE_LATENCY = ray_dispatcher_pkg::CORE_LATENCY,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  World_s             world_i,
    output logic               busy,
    output logic               frame_done,
    output World_s             core_world,
    output Pixel_s             core_pixel,
    input  logic               core_less_than_zero,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_hit,
    output logic [ADDR_W-1:0]  res_addr,
    output logic               res_last
`ifdef RAY_HIT_COUNT_EN
    ,
    output logic [ADDR_W-1:0]  hit_count
`endif
);
    localparam int NPIX  = H_RES * V_RES;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    disp_state_e          r_state;
    disp_state_e          w_state_nxt;
    World_s               r_core_world;
    Pixel_s               r_core_pixel;
    Pixel_s               w_pix;
    logic [COORD_W-1:0]   r_col;
    logic [COORD_W-1:0]   r_row;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [CORE_LATENCY:0] r_vld_pipe;
    logic [CNT_W-1:0]     w_inflight;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [CNT_W:0]       w_credit_sum;
    logic                 w_start_acc;
    logic                 w_issue;
    logic                 w_last_pix;
    logic                 w_push;
    logic                 w_pop;
    logic [RES_W-1:0]     w_push_data;
    logic [RES_W-1:0]     w_head;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_last_pix   = (r_col == COORD_W'(H_RES-1)) && (r_row == COORD_W'(V_RES-1));
    assign w_inflight   = CNT_W'($countones(r_vld_pipe));
    assign w_credit_sum = {1'b0, w_inflight} + {1'b0, w_fifo_count};
    assign w_issue      = (r_state == ST_RUN) && (w_credit_sum < (CNT_W+1)'(FIFO_DEPTH));
    // Bit k of the pipe marks the pixel presented k cycles ago; the top bit lines up with the core result.
    assign w_push       = r_vld_pipe[CORE_LATENCY];
    assign w_pop        = res_valid && res_ready;
    assign w_push_data  = {~core_less_than_zero, r_wr_addr, (r_wr_addr == ADDR_W'(NPIX-1))};

    assign w_pix.x = signed'(r_col) - COORD_W'(H_RES/2);
    assign w_pix.y = COORD_W'(V_RES/2) - signed'(r_row);
    assign w_pix.z = COORD_W'(FOCAL_Z);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_core_world <= '0;
            r_core_pixel <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_wr_addr    <= '0;
            r_vld_pipe   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vld_pipe <= {r_vld_pipe[CORE_LATENCY-1:0], w_issue};
            if (w_start_acc) begin
                r_core_world <= world_i;
                r_col        <= '0;
                r_row        <= '0;
                r_wr_addr    <= '0;
            end else begin
                if (w_issue) begin
                    r_core_pixel <= w_pix;
                    if (r_col == COORD_W'(H_RES-1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                if (w_push) r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_issue && w_last_pix) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && res_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    hit_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (res_valid),
        .count     (w_fifo_count)
    );

    assign {res_hit, res_addr, res_last} = w_head;
    assign core_world = r_core_world;
    assign core_pixel = r_core_pixel;

`ifdef RAY_HIT_COUNT_EN
    logic [ADDR_W-1:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_count <= '0;
        end else if (w_start_acc) begin
            r_hit_count <= '0;
        end else if (w_pop && res_hit) begin
            r_hit_count <= r_hit_count + 1'b1;
        end
    end

    assign hit_count = r_hit_count;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher on an 8x4 screen with a 5-cycle behavioural core.
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int HR   = 8;
    localparam int VR   = 4;
    localparam int NPX  = HR * VR;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    World_s            world_i;
    logic              busy;
    logic              frame_done;
    World_s            core_world;
    Pixel_s            core_pixel;
    logic              core_less_than_zero;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [ADDR_W-1:0] res_addr;
    logic              res_last;
`ifdef RAY_HIT_COUNT_EN
    logic [ADDR_W-1:0] hit_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int issues = 0;
    logic [RES_W-1:0] sb[$];
    logic [4:0] core_sh;

    always #5 clk = ~clk;

    ray_dispatcher #(
        .H_RES (HR),
        .V_RES (VR)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .world_i             (world_i),
        .busy                (busy),
        .frame_done          (frame_done),
        .core_world          (core_world),
        .core_pixel          (core_pixel),
        .core_less_than_zero (core_less_than_zero),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_hit             (res_hit),
        .res_addr            (res_addr),
        .res_last            (res_last)
`ifdef RAY_HIT_COUNT_EN
        ,
        .hit_count           (hit_count)
`endif
    );

    // Behavioural core: free-running 5-stage pipe, less_than_zero = (x < 0).
    initial core_sh = '0;
    always @(posedge clk) core_sh <= {core_sh[3:0], core_pixel.x[COORD_W-1]};
    assign core_less_than_zero = core_sh[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        logic [RES_W-1:0] e;
        for (int i = 0; i < NPX; i++) begin
            e = {((i % HR) >= HR/2) ? 1'b1 : 1'b0, ADDR_W'(i), (i == NPX-1) ? 1'b1 : 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (!frame_done && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        check(nm, {63'b0, frame_done}, 64'd1);
    endtask

    // Monitor: pops expected results on handshakes, checks hold stability, counts issues.
    initial begin
        logic             pv, pr;
        logic [RES_W-1:0] pd;
        logic [RES_W-1:0] got;
        logic [RES_W-1:0] exp;
        Pixel_s           ppix;
        pv = 1'b0; pr = 1'b0; pd = '0; ppix = '0;
        forever begin
            @(negedge clk);
            got = {res_hit, res_addr, res_last};
            if (core_pixel != ppix) issues++;
            ppix = core_pixel;
            if (rst_n === 1'b1) begin
                if (pv && !pr) begin
                    check("hold_valid", {63'b0, res_valid}, 64'd1);
                    check("hold_data", {43'b0, got}, {43'b0, pd});
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", {43'b0, got}, 64'h0);
                        n_err += (got == '0) ? 1 : 0;
                    end else begin
                        exp = sb.pop_front();
                        check($sformatf("res_addr%0d", exp[ADDR_W:1]), {43'b0, got}, {43'b0, exp});
                    end
                end
                pv = res_valid; pr = res_ready; pd = got;
            end else begin
                pv = 1'b0; pr = 1'b0; pd = '0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        World_s w1, w2;
        Pixel_s p0;
        int c, base;
        w1 = '{cx: 16'sd5, cy: -16'sd3, cz: 16'sd100, radius_sq: 16'd49};
        w2 = '{cx: -16'sd7, cy: 16'sd9, cz: 16'sd60, radius_sq: 16'd25};
        p0 = '{x: -16'sd4, y: 16'sd2, z: 16'sd31};

        // Reset with start held high.
        rst_n = 1'b0; start = 1'b1; world_i = w1; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_frame_done", {63'b0, frame_done}, 64'd0);
        check("rst_res_valid", {63'b0, res_valid}, 64'd0);
        check("rst_res", {43'b0, res_hit, res_addr, res_last}, 64'd0);
        check("rst_core_pixel", {16'b0, core_pixel}, 64'd0);
        check("rst_core_world", core_world, 64'd0);
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", {63'b0, busy}, 64'd0);

        // Full frame with ready held high.
        push_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        @(posedge clk); #1;
        check("first_pixel", {16'b0, core_pixel}, {16'b0, p0});
        check("world_latched", core_world, w1);
        c = 2;
        while (!frame_done && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("frame_done_cycle", 64'(c), 64'd40);
`ifdef RAY_HIT_COUNT_EN
        @(posedge clk); #1;
        check("hit_count_frame", {45'b0, hit_count}, 64'd16);
`else
        @(posedge clk); #1;
`endif
        check("frame_done_pulse", {63'b0, frame_done}, 64'd0);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        check("sb_drained_1", 64'(sb.size()), 64'd0);

        // Backpressure frame with a mid-frame start and world change.
        res_ready = 1'b0;
        push_frame();
        base = issues;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef RAY_HIT_COUNT_EN
        check("hit_count_clear", {45'b0, hit_count}, 64'd0);
`endif
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; world_i = w2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("credit_issues", 64'(issues - base), 64'd16);
        check("bp_valid", {63'b0, res_valid}, 64'd1);
        check("bp_head_addr", {45'b0, res_addr}, 64'd0);
        check("world_held", core_world, w1);
        res_ready = 1'b1;
        wait_done("bp_frame_done");
        check("world_held_end", core_world, w1);
        @(posedge clk); #1;
        check("sb_drained_2", 64'(sb.size()), 64'd0);

        // Reset one cycle after pixel 10 issues.
        world_i = w1;
        push_frame();
        base = issues;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while ((issues - base) < 11 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("pixel10_seen", 64'((issues - base) >= 11), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_valid", {63'b0, res_valid}, 64'd0);
        check("mid_rst_res", {43'b0, res_hit, res_addr, res_last}, 64'd0);
        check("mid_rst_pixel", {16'b0, core_pixel}, 64'd0);
        check("mid_rst_world", core_world, 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_valid", {63'b0, res_valid}, 64'd0);
        push_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart_frame_done");
`ifdef RAY_HIT_COUNT_EN
        @(posedge clk); #1;
        check("hit_count_restart", {45'b0, hit_count}, 64'd16);
`else
        @(posedge clk); #1;
`endif
        check("sb_drained_3", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame sequencer driving the input side of the ray-trace core and collecting its output. Per frame it latches one `World_s`, walks the screen in raster order, and issues one `Pixel_s` ray direction per cycle into the core's free-running pipeline. It tracks the core's fixed latency with a valid shift register and realigns each returning `less_than_zero` with its pixel. Results go out as an in-order hit stream with valid/ready, toward the framebuffer writer.

## Interface
- `H_RES`, 640, screen width in pixels
- `V_RES`, 480, screen height in pixels
- `FOCAL_Z`, 31, constant `pixel.z` for every ray
- `CORE_LATENCY`, 5, cycles from `core_pixel` presented to the matching `core_less_than_zero`
- `FIFO_DEPTH`, 16, result FIFO entries (power of two)
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a frame; sampled in IDLE only
- `world_i`  in  `World_s`  scene; latched on accepted `start`
- `busy`  out  1  high from accepted `start` until the `frame_done` cycle inclusive
- `frame_done`  out  1  one-cycle pulse after the last result handshake
- `core_world`  out  `World_s`  latched scene, held stable for the whole frame
- `core_pixel`  out  `Pixel_s`  registered ray direction
- `core_less_than_zero`  in  1  core discriminant sign
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts
- `res_hit`  out  1  `~less_than_zero` (1 = ray hits sphere)
- `res_addr`  out  19  linear pixel index, row*H_RES+col
- `res_last`  out  1  high with the final pixel of the frame

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`: latch `world_i` into `core_world`; clear `col`, `row`, `wr_addr`.
  - RUN issues a pixel in each cycle where `inflight + fifo_count < FIFO_DEPTH` (credit rule). The core cannot stall, so no result is ever dropped.
  - RUN→DRAIN the cycle the pixel at `col=H_RES-1`, `row=V_RES-1` issues.
  - DRAIN→DONE on the handshake where `res_last` is high.
  - DONE→IDLE unconditionally; `frame_done=1` in DONE.
- Issue: `core_pixel.x = col - H_RES/2` (signed, -320..319), `.y = V_RES/2 - row` (240..-239), `.z = FOCAL_Z`. `col` increments each issue and wraps at H_RES, incrementing `row`.
- A valid pipe of CORE_LATENCY bits is shifted every cycle. On an issue, a 1 enters the pipe on the same edge that updates `core_pixel`. When the pipe outputs a 1, `core_less_than_zero` is written into the FIFO.
- `inflight` = popcount of the valid pipe; an up/down counter is acceptable.
- Results return in order. `res_addr` comes from `wr_addr`, which increments per FIFO push. `res_last` is set when `wr_addr == H_RES*V_RES-1`.
- Push and pop in the same cycle are legal, including with the FIFO full (pop first).
- `start` in any state other than IDLE is ignored. `world_i` changes mid-frame have no effect.
- Reset mid-frame: FSM→IDLE; counters, valid pipe and FIFO cleared. Stale core outputs are discarded because the pipe is zero.

## Timing
- Reset values: `busy=0`, `frame_done=0`, `res_valid=0`, `res_hit=0`, `res_addr=0`, `res_last=0`, `core_pixel=0`, `core_world=0`.
- First `core_pixel` is valid the cycle after `start` is accepted.
- Result for a pixel driven in cycle n is sampled from `core_less_than_zero` in cycle n+CORE_LATENCY and is visible on `res_valid` in cycle n+CORE_LATENCY+1.
- With `res_ready=1` held: one result per cycle, and the frame takes H_RES*V_RES + CORE_LATENCY + 3 cycles from `start` to `frame_done`.
- `res_*` stay stable while `res_valid=1` and `res_ready=0`.

## Configuration
- `RAY_HIT_COUNT_EN` defined: adds output `hit_count[18:0]`. It counts `res_hit=1` handshakes, clears on accepted `start`, holds its value after `frame_done`, and resets to 0.
- `RAY_HIT_COUNT_EN` undefined: the port and the counter are absent.

## Structure
- Shared package: `Pixel_s`, `World_s` (existing), plus `SCREEN_W=640`, `SCREEN_H=480`, `CORE_LATENCY=5`, and the dispatcher state enum.
- One sub-module, `hit_fifo`: synchronous FIFO, 1+19+1 bits wide, FIFO_DEPTH entries, with `count` output used for credit.

## Test plan
Benches use H_RES=8, V_RES=4 and a behavioural core model with 5-cycle latency that returns `less_than_zero=1` for `x<0`.
1. Hold `rst_n=0` for 3 cycles → all outputs at their reset values; `start` ignored while in reset.
2. Pulse `start`, `res_ready=1` → first `core_pixel` = (-4, 2, 31); 32 results with `res_addr` 0..31; `res_hit=1` exactly for cols 4..7; `res_last` only at addr 31; `frame_done` pulses 40 cycles after `start`.
3. Hold `res_ready=0` → issuing stops once 16 results are buffered or in flight. Release → addresses continue contiguously with none lost or duplicated.
4. Pulse `start` again mid-frame and change `world_i` → no restart, and `core_world` holds the first latched value.
5. Assert `rst_n=0` one cycle after pixel 10 issues → reset values next cycle. A new `start` restarts at `res_addr=0` with no stale results.
6. With `RAY_HIT_COUNT_EN` defined, run a full frame → `hit_count=16` after `frame_done`; it clears to 0 on the next `start`.
